div_unit: RTL and testbench

Iterative radix-2 restoring integer divider for the CPU execute stage. It accepts one signed or unsigned divide per Start pulse. While it runs, it drives DivStall, which feeds the control unit's stall logic and freezes the instruction pipeline until the quotient and remainder are ready. The execute-stage result mux consumes Quot/Rem on the Done cycle.

---
 rtl/div_unit_pkg.sv | 6 +
 rtl/div_sign_fix.sv | 10 +
 rtl/div_unit.sv | 71 +++++++
 tb/tb_div_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared CPU datapath width and divider state encodings
package div_unit_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10} state_t;
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate
module div_sign_fix #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring signed/unsigned divider with pipeline stall
module div_unit import div_unit_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             DivStall,
  output logic             Done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             DivZero
);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic sa, sb, last, dz;
  logic [WIDTH-1:0] dvd, dvs, prem, a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0] diff;
  assign last = cnt == CNT_W'(WIDTH-1);
  assign dz = dvs == '0;
  assign diff = {prem, dvd[WIDTH-1]} - {1'b0, dvs};
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.a(A), .neg(Signed & A[WIDTH-1]), .y(a_abs));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.a(B), .neg(Signed & B[WIDTH-1]), .y(b_abs));
  // With B=0 every trial succeeds, leaving all-ones and |A|; re-signing Rem restores A
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.a(dvd), .neg((sa ^ sb) & ~dz), .y(q_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.a(prem), .neg(sa), .y(r_fix));
  always_comb begin
    nxt = state == IDLE ? (Start ? CALC : IDLE) : state == CALC ? (last ? FIX : CALC) : IDLE;
    DivStall = state != IDLE || Start;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      dvd <= '0;
      dvs <= '0;
      prem <= '0;
      Done <= 1'b0;
      Quot <= '0;
      Rem <= '0;
      DivZero <= 1'b0;
    end else begin
      Done <= state == FIX;
      if (state == IDLE && Start) begin
        sa <= Signed & A[WIDTH-1];
        sb <= Signed & B[WIDTH-1];
        dvd <= a_abs;
        dvs <= b_abs;
        prem <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        cnt <= cnt + CNT_W'(1);
        dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
        prem <= diff[WIDTH] ? {prem[WIDTH-2:0], dvd[WIDTH-1]} : diff[WIDTH-1:0];
      end else if (state == FIX) begin
        Quot <= q_fix;
        Rem <= r_fix;
        DivZero <= dz;
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
  logic clk = 1'b0, rst = 1'b0, Start = 1'b0, Signed = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic DivStall, Done, DivZero;
  logic [15:0] Quot, Rem;
  int errors = 0, checks = 0;

  div_unit dut (.clk(clk), .rst(rst), .Start(Start), .Signed(Signed), .A(A), .B(B),
                .DivStall(DivStall), .Done(Done), .Quot(Quot), .Rem(Rem), .DivZero(DivZero));

  always #5 clk = ~clk;

  // Launch one divide and run until Done, returning what was observed
  task automatic divide(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output int stalls, output bit got, output logic [15:0] q,
                        output logic [15:0] r, output logic dz, output logic st_done);
    @(negedge clk);
    A = a; B = b; Signed = s; Start = 1'b1;
    #1 stalls = DivStall ? 1 : 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (Done) got = 1'b1;
      else if (DivStall) stalls++;
      Start = 1'b0;
    end
    q = Quot; r = Rem; dz = DivZero; st_done = DivStall;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (Quot !== 16'h0 || Rem !== 16'h0) begin errors++; $display("FAIL reset_qr: Quot=%h Rem=%h want 0 0", Quot, Rem); end
    checks++; if (Done !== 1'b0 || DivZero !== 1'b0 || DivStall !== 1'b0) begin errors++; $display("FAIL reset_flags: Done=%b DivZero=%b DivStall=%b want 0 0 0", Done, DivZero, DivStall); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_unsigned();
    int st; bit got; logic [15:0] q, r; logic dz, sd;
    divide(16'd100, 16'd7, 1'b0, st, got, q, r, dz, sd);
    checks++; if (st !== 18) begin errors++; $display("FAIL u_stall_len: got %0d want 18", st); end
    checks++; if (!got) begin errors++; $display("FAIL u_done: no Done want Done"); end
    checks++; if (q !== 16'd14 || r !== 16'd2 || dz !== 1'b0) begin errors++; $display("FAIL u_100_7: q=%h r=%h dz=%b want 000e 0002 0", q, r, dz); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL u_stall_done: DivStall=%b want 0", sd); end
    @(negedge clk);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL u_done_pulse: Done=%b want 0", Done); end
  endtask

  task automatic test_signed();
    int st; bit got; logic [15:0] q, r; logic dz, sd;
    divide(16'hFF9C, 16'd7, 1'b1, st, got, q, r, dz, sd);
    checks++; if (!got || st !== 18 || q !== 16'hFFF2 || r !== 16'hFFFE) begin errors++; $display("FAIL s_m100_7: got=%b st=%0d q=%h r=%h want 1 18 fff2 fffe", got, st, q, r); end
    divide(16'd100, 16'hFFF9, 1'b1, st, got, q, r, dz, sd);
    checks++; if (!got || q !== 16'hFFF2 || r !== 16'h0002) begin errors++; $display("FAIL s_100_m7: got=%b q=%h r=%h want 1 fff2 0002", got, q, r); end
  endtask

  task automatic test_divzero();
    int st; bit got; logic [15:0] q, r; logic dz, sd;
    divide(16'h1234, 16'h0, 1'b1, st, got, q, r, dz, sd);
    checks++; if (!got || st !== 18 || q !== 16'hFFFF || r !== 16'h1234 || dz !== 1'b1) begin errors++; $display("FAIL dz_1234: got=%b st=%0d q=%h r=%h dz=%b want 1 18 ffff 1234 1", got, st, q, r, dz); end
    divide(16'hFF9C, 16'h0, 1'b1, st, got, q, r, dz, sd);
    checks++; if (!got || q !== 16'hFFFF || r !== 16'hFF9C || dz !== 1'b1) begin errors++; $display("FAIL dz_neg: got=%b q=%h r=%h dz=%b want 1 ffff ff9c 1", got, q, r, dz); end
    divide(16'd6, 16'd3, 1'b0, st, got, q, r, dz, sd);
    checks++; if (!got || q !== 16'd2 || r !== 16'd0 || dz !== 1'b0) begin errors++; $display("FAIL dz_clear: got=%b q=%h r=%h dz=%b want 1 0002 0000 0", got, q, r, dz); end
  endtask

  task automatic test_overflow();
    int st; bit got; logic [15:0] q, r; logic dz, sd;
    divide(16'h8000, 16'hFFFF, 1'b1, st, got, q, r, dz, sd);
    checks++; if (!got || q !== 16'h8000 || r !== 16'h0 || dz !== 1'b0) begin errors++; $display("FAIL ovf_signed: got=%b q=%h r=%h dz=%b want 1 8000 0000 0", got, q, r, dz); end
    divide(16'h8000, 16'hFFFF, 1'b0, st, got, q, r, dz, sd);
    checks++; if (!got || q !== 16'h0 || r !== 16'h8000) begin errors++; $display("FAIL ovf_unsigned: got=%b q=%h r=%h want 1 0000 8000", got, q, r); end
  endtask

  task automatic test_back_to_back();
    int dones = 0, t1 = -1, t2 = -1;
    logic st_at_done = 1'b0;
    logic [15:0] q1 = '0, r1 = '0, q_mid = '0;
    @(negedge clk);
    A = 16'd20; B = 16'd3; Signed = 1'b0; Start = 1'b1;
    for (int i = 1; i < 60 && t2 < 0; i++) begin
      @(negedge clk);
      if (i == 27) q_mid = Quot;
      if (Done) begin
        dones++;
        if (t1 < 0) begin
          t1 = i; q1 = Quot; r1 = Rem; st_at_done = DivStall;
          A = 16'd50; B = 16'd4;
        end else t2 = i;
      end
      if (t1 >= 0 && i == t1 + 1) Start = 1'b0;
    end
    checks++; if (t1 !== 18) begin errors++; $display("FAIL b2b_first_done: cycle %0d want 18", t1); end
    checks++; if (q1 !== 16'd6 || r1 !== 16'd2) begin errors++; $display("FAIL b2b_first_res: q=%h r=%h want 0006 0002", q1, r1); end
    checks++; if (st_at_done !== 1'b1) begin errors++; $display("FAIL b2b_stall_done: DivStall=%b want 1", st_at_done); end
    checks++; if (q_mid !== 16'd6) begin errors++; $display("FAIL b2b_hold: Quot=%h want 0006", q_mid); end
    checks++; if (t2 !== 36 || dones !== 2) begin errors++; $display("FAIL b2b_second_done: cycle %0d dones %0d want 36 2", t2, dones); end
    checks++; if (Quot !== 16'd12 || Rem !== 16'd2) begin errors++; $display("FAIL b2b_second_res: q=%h r=%h want 000c 0002", Quot, Rem); end
  endtask

  task automatic test_reset_mid();
    int st; bit got; logic [15:0] q, r; logic dz, sd;
    int late = 0;
    divide(16'h0055, 16'h0, 1'b0, st, got, q, r, dz, sd);
    @(negedge clk);
    A = 16'd1000; B = 16'd10; Signed = 1'b0; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (Quot !== 16'h0 || Rem !== 16'h0 || DivZero !== 1'b0 || Done !== 1'b0 || DivStall !== 1'b0) begin errors++; $display("FAIL mid_reset: q=%h r=%h dz=%b done=%b stall=%b want 0 0 0 0 0", Quot, Rem, DivZero, Done, DivStall); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (Done) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL mid_no_done: %0d Done pulses want 0", late); end
    divide(16'd1000, 16'd7, 1'b0, st, got, q, r, dz, sd);
    checks++; if (!got || st !== 18 || q !== 16'd142 || r !== 16'd6 || dz !== 1'b0) begin errors++; $display("FAIL mid_recover: got=%b st=%0d q=%h r=%h dz=%b want 1 18 008e 0006 0", got, st, q, r, dz); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
